// File: rtl/hssaer_paer_merge_pkg.sv
// Shared definitions for the HSSAER-to-PAER merge block.
// Optional event counter is enabled by defining HSSAER_MERGE_EVTCNT_EN.
package hssaer_paer_merge_pkg;

  localparam int    EVT_CNT_W    = 16;
  localparam string EVTCNT_MACRO = "HSSAER_MERGE_EVTCNT_EN";
  localparam int    PACK_W       = 64;

  // Output word layout is {channel index, event address}.
  function automatic logic [PACK_W-1:0] pack_word(input logic [PACK_W-1:0] ch,
                                                  input logic [PACK_W-1:0] ae,
                                                  input int                dsize);
    return (ch << dsize) | ae;
  endfunction

endpackage

// File: rtl/hssaer_sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the head word while !empty.
module hssaer_sync_fifo
  import hssaer_paer_merge_pkg::*;
#(
  parameter int width      = 10,
  parameter int depth_log2 = 4
) (
  input  logic             clkp,
  input  logic             _rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int depth = 2 ** depth_log2;

  logic [width-1:0]      mem [depth];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic [depth_log2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is deliberately left out of reset.
  always_ff @(posedge clkp) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign full  = (count == (depth_log2 + 1)'(depth));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/hssaer_paer_merge.sv
// Round-robin merge of 2**chw AER links into one {ch, ae} tagged stream.
// Define HSSAER_MERGE_EVTCNT_EN to build the saturating evt_cnt counter.
module hssaer_paer_merge
  import hssaer_paer_merge_pkg::*;
#(
  parameter int dsize      = 8,
  parameter int chw        = 2,
  parameter int depth_log2 = 4
) (
  input  logic                     clkp,
  input  logic                     _rst,
  input  logic [(2**chw)*dsize-1:0] ae_in,
  input  logic [(2**chw)-1:0]      src_rdy_in,
  output logic [(2**chw)-1:0]      dst_rdy_in,
  output logic [chw+dsize-1:0]     ae_out,
  output logic                     src_rdy_out,
  input  logic                     dst_rdy_out,
  output logic                     ovf,
  output logic [EVT_CNT_W-1:0]     evt_cnt
);

  localparam int nch = 2 ** chw;

  logic [chw-1:0]       rr;
  logic [chw-1:0]       grant_idx;
  logic                 grant_vld;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [dsize-1:0]     ae_sel;
  logic [chw+dsize-1:0] fifo_din;

  // Scan from the farthest offset back to rr so the nearest requester wins.
  always_comb begin
    logic [chw-1:0] idx;
    grant_idx = rr;
    grant_vld = 1'b0;
    idx       = rr;
    for (int i = nch - 1; i >= 0; i--) begin
      idx = rr + chw'(i);
      if (src_rdy_in[idx]) begin
        grant_idx = idx;
        grant_vld = 1'b1;
      end
    end
  end

  // Gating on full alone keeps dst_rdy_out out of the dst_rdy_in path.
  always_comb begin
    dst_rdy_in = '0;
    if (grant_vld && !full) dst_rdy_in[grant_idx] = 1'b1;
  end

  assign push     = grant_vld && !full;
  assign pop      = src_rdy_out && dst_rdy_out;
  assign ae_sel   = ae_in[grant_idx*dsize +: dsize];
  assign fifo_din = (chw + dsize)'(pack_word(PACK_W'(grant_idx), PACK_W'(ae_sel), dsize));

  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      rr  <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) rr <= grant_idx + 1'b1;
      if (full && |src_rdy_in) ovf <= 1'b1;
    end
  end

  hssaer_sync_fifo #(
    .width      (chw + dsize),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clkp  (clkp),
    ._rst  (_rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (ae_out),
    .full  (full),
    .empty (empty)
  );

  assign src_rdy_out = !empty;

`ifdef HSSAER_MERGE_EVTCNT_EN
  logic [EVT_CNT_W-1:0] cnt;

  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      cnt <= '0;
    end else if (push && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign evt_cnt = cnt;
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: doc/hssaer_paer_merge.md
Name: hssaer_paer_merge

Overview:
- Merges 2**chw parallel AER event streams from per-link HSSAER receivers into one tagged stream.
- Each input uses the ae/src_rdy/dst_rdy handshake of the receiver wrapper.
- A round-robin arbiter admits at most one event per cycle into a show-ahead FIFO.
- FIFO output word is {channel index, ae}; it feeds the downstream event sink (DMA/host interface) using the same handshake.

Parameters:
- dsize, 8, event address width per channel.
- chw, 2, channel-index width; number of channels nch = 2**chw (chw >= 1).
- depth_log2, 4, FIFO depth = 2**depth_log2 words.

Ports:
- clkp  in  1  clock, rising edge.
- _rst  in  1  reset, asynchronous, active-low.
- ae_in  in  nch*dsize  channel i occupies bits [i*dsize +: dsize].
- src_rdy_in  in  nch  per-channel event valid; held by producer until accepted.
- dst_rdy_in  out  nch  per-channel accept, combinational.
- ae_out  out  chw+dsize  head word {ch, ae}.
- src_rdy_out  out  1  FIFO not empty.
- dst_rdy_out  in  1  consumer accept.
- ovf  out  1  sticky: some channel was refused for a full FIFO.
- evt_cnt  out  16  accepted-event counter; see Optional Feature.

Behaviour:
- Transfer rule, both sides: a word moves on a rising clkp edge where src_rdy && dst_rdy are both high. Producers and consumers may hold src_rdy across cycles; ae is stable while src_rdy is high.
- Arbiter:
  - Pointer rr (chw bits) is reset to 0.
  - Grant goes to the first i in the order rr, rr+1, ... (mod nch) with src_rdy_in[i]=1.
  - dst_rdy_in[i] = grant[i] && !full. At most one bit is high.
  - On a push, rr <= granted index + 1 (wraps).
  - With no push, rr holds.
- FIFO:
  - Write pointer, read pointer (depth_log2 bits, wrap naturally) and count (depth_log2+1 bits).
  - full = (count == 2**depth_log2); empty = (count == 0).
  - push = |(src_rdy_in & dst_rdy_in); pop = src_rdy_out && dst_rdy_out.
  - Push while full is never possible, even if a pop occurs in the same cycle. This breaks the combinational path from dst_rdy_out to dst_rdy_in.
  - Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
  - Push into empty: the word appears on ae_out with src_rdy_out=1 on the next cycle (latency 1).
  - Output is show-ahead: ae_out = mem[rd_ptr], src_rdy_out = !empty. ae_out is undefined when empty, and the bench must not check it then.
- ovf:
  - Set on any edge where full && |src_rdy_in.
  - Cleared only by reset.
  - Informational only; no event is lost, because the producer holds its event.
- Reset values:
  - dst_rdy_in follows src_rdy_in and grant (FIFO is empty after reset).
  - src_rdy_out=0, ovf=0, evt_cnt=0; pointers, count and rr = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all buffered words immediately (asynchronous). A producer still holding src_rdy is re-arbitrated after reset release.

Optional Feature:
- Macro: HSSAER_MERGE_EVTCNT_EN.
- Defined: evt_cnt increments by 1 on every push and saturates at 16'hFFFF; reset to 0.
- Undefined: the evt_cnt port remains and is tied to 0; no counter logic is instantiated.

Decomposition:
- Shared package holds:
  - the helper that packs the output word {ch, ae};
  - the evt_cnt width constant (16);
  - the macro name.
- One sub-module: hssaer_sync_fifo, a single-clock show-ahead FIFO with parameters width and depth_log2, ports push/pop/din/dout/full/empty, same clock and reset.
- The arbiter stays inline.

Test Plan:
- Single event, ch2, ae=8'hA5, output idle-ready → dst_rdy_in=4'b0100 for one cycle; next cycle ae_out=10'h2A5, src_rdy_out=1; evt_cnt=1 with macro.
- All four channels held valid, dst_rdy_out=1 → accept order ch0,1,2,3,0..., one per cycle; output sequence tags 0,1,2,3 in order.
- dst_rdy_out=0, ch1 streams 17 events → 16 accepted, full=1; 17th is held with dst_rdy_in[1]=0 and ovf=1; after one pop the held event is accepted on the following cycle; no word is lost or duplicated.
- Full FIFO with simultaneous pop and pending input → no push that cycle; push on the next cycle; count goes 16→15→16.
- Assert _rst with 5 words buffered → src_rdy_out=0, ovf=0, evt_cnt=0 immediately; after release a held ch3 event (ae=8'h3C) emerges as 10'h33C.
- Macro on: force 65536 pushes (or preload the counter) → evt_cnt holds at 16'hFFFF; macro off: evt_cnt stays 0 throughout.
